// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Instruction-ROM bus, fetch-to-decode valid/ready handshake
//               and branch-redirect / stall inputs of the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
   // Instruction ROM: address out, combinational read data back
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;

   // One-entry fetch buffer toward decode
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        id_ready;

   // Control from the datapath
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        freeze;

   // The sequencer itself
   modport master (
      output imem_addr,
      input  imem_instr,
      output if_valid,
      output if_instr,
      output if_pc,
      input  id_ready,
      input  redirect_valid,
      input  redirect_target,
      input  freeze
   );

   // ROM, decode stage and datapath as seen from the other side
   modport slave (
      input  imem_addr,
      output imem_instr,
      input  if_valid,
      input  if_instr,
      input  if_pc,
      output id_ready,
      output redirect_valid,
      output redirect_target,
      output freeze
   );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Program-counter sequencer and fetch controller. Addresses a
//               combinational instruction ROM, captures the returned word and
//               its PC into a one-entry buffer handed to decode over a
//               valid/ready handshake, follows branch redirects, halts at the
//               end of the program and traps illegal redirect targets.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter int unsigned MEM_BYTES = 32,
   parameter logic [63:0] RESET_PC  = 64'd0
) (
   input  wire logic          clk,
   input  wire logic          reset,
   fetch_sequencer_if.master  bus,
   output logic               done,
   output logic               fault,
   output logic [63:0]        fault_addr,
   output logic [31:0]        issue_count
);

   // ROM size widened by one bit so that address + offset never wraps
   localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DONE  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // Registered state
   state_t      state;
   logic [63:0] pc;
   logic        buf_valid;
   logic [31:0] buf_instr;
   logic [63:0] buf_pc;
   logic [63:0] fault_addr_q;
   logic [31:0] count;

   // Next-state values
   state_t      state_n;
   logic [63:0] pc_n;
   logic        buf_valid_n;
   logic [31:0] buf_instr_n;
   logic [63:0] buf_pc_n;
   logic [63:0] fault_addr_n;
   logic [31:0] count_n;

   // Decoded conditions
   logic        slot_free;
   logic        fetch;
   logic        accept;
   logic        target_illegal;
   logic        at_last_word;
   logic [64:0] target_end;
   logic [64:0] next_word_end;

   // A redirect target is legal only if it is word-aligned and the whole
   // word lies inside the ROM; the compare is done one bit wider so huge
   // targets near 2^64 cannot wrap into range.
   assign target_end     = {1'b0, bus.redirect_target} + 65'd3;
   assign target_illegal = (bus.redirect_target[1:0] != 2'b00) ||
                           (target_end >= MEM_LIMIT);

   // The word at pc is the last one when the following word would not fit.
   assign next_word_end  = {1'b0, pc} + 65'd7;
   assign at_last_word   = (next_word_end >= MEM_LIMIT);

   assign slot_free = !buf_valid || bus.id_ready;
   assign fetch     = (state == ST_RUN) && slot_free && !bus.freeze &&
                      !bus.redirect_valid;
   // A buffered instruction taken by decode in the same cycle as a redirect
   // is the wrong-path one and is not counted.
   assign accept    = buf_valid && bus.id_ready && !bus.redirect_valid;

   // Next-state logic: redirect beats freeze, freeze beats sequential fetch
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      buf_valid_n  = buf_valid;
      buf_instr_n  = buf_instr;
      buf_pc_n     = buf_pc;
      fault_addr_n = fault_addr_q;
      count_n      = count;

      if (accept) begin
         count_n = count + 32'd1;
      end

      case (state)
         ST_FAULT: begin
            // Absorbing: nothing but reset leaves this state
            buf_valid_n = 1'b0;
         end

         ST_RUN, ST_DONE: begin
            if (bus.redirect_valid) begin
               buf_valid_n = 1'b0;
               if (target_illegal) begin
                  state_n      = ST_FAULT;
                  fault_addr_n = bus.redirect_target;
               end else begin
                  state_n = ST_RUN;
                  pc_n    = bus.redirect_target;
               end
            end else if (fetch) begin
               buf_valid_n = 1'b1;
               buf_instr_n = bus.imem_instr;
               buf_pc_n    = pc;
               if (at_last_word) begin
                  state_n = ST_DONE;
               end else begin
                  pc_n = pc + 64'd4;
               end
            end else if (bus.id_ready && buf_valid) begin
               buf_valid_n = 1'b0;
            end
         end

         default: begin
            state_n     = ST_FAULT;
            buf_valid_n = 1'b0;
         end
      endcase
   end

   // State register with immediate (asynchronous) reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_RUN;
         pc           <= RESET_PC;
         buf_valid    <= 1'b0;
         buf_instr    <= 32'd0;
         buf_pc       <= 64'd0;
         fault_addr_q <= 64'd0;
         count        <= 32'd0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         buf_valid    <= buf_valid_n;
         buf_instr    <= buf_instr_n;
         buf_pc       <= buf_pc_n;
         fault_addr_q <= fault_addr_n;
         count        <= count_n;
      end
   end

   assign bus.imem_addr = pc;
   assign bus.if_valid  = buf_valid;
   assign bus.if_instr  = buf_instr;
   assign bus.if_pc     = buf_pc;
   assign done          = (state == ST_DONE);
   assign fault         = (state == ST_FAULT);
   assign fault_addr    = fault_addr_q;
   assign issue_count   = count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer: directed scenarios
//               followed by randomized episodes, compared every cycle against
//               a behavioural model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   localparam int unsigned MEM = 32;

   logic        clk;
   logic        reset;
   logic        done;
   logic        fault;
   logic [63:0] fault_addr;
   logic [31:0] issue_count;
   logic [31:0] rom [8];

   int n_checks = 0;
   int n_errors = 0;

   fetch_sequencer_if bus();

   fetch_sequencer #(.MEM_BYTES(MEM), .RESET_PC(64'd0)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.master),
      .done        (done),
      .fault       (fault),
      .fault_addr  (fault_addr),
      .issue_count (issue_count)
   );

   // Combinational ROM
   assign bus.imem_instr = rom[bus.imem_addr[4:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what decode should see, described as plain variables
   logic [63:0] m_pc;
   bit          m_valid;
   logic [31:0] m_instr;
   logic [63:0] m_ifpc;
   bit          m_done;
   bit          m_fault;
   logic [63:0] m_faddr;
   logic [31:0] m_count;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 64'd0; m_valid = 0; m_instr = 32'd0; m_ifpc = 64'd0;
      m_done = 0; m_fault = 0; m_faddr = 64'd0; m_count = 32'd0;
   endtask

   // One clock edge of the fetch rules
   task automatic model_edge(input bit rdy, input bit frz, input bit rv, input logic [63:0] tgt);
      bit illegal;
      if (m_valid && rdy && !rv) m_count = m_count + 32'd1;
      illegal = (tgt % 4 != 0) || (tgt >= 64'(MEM - 3));
      if (m_fault) begin
         m_valid = 0;
      end else if (rv) begin
         m_valid = 0;
         m_done  = 0;
         if (illegal) begin
            m_fault = 1;
            m_faddr = tgt;
         end else begin
            m_pc = tgt;
         end
      end else if (!m_done && (!m_valid || rdy) && !frz) begin
         m_instr = rom[m_pc / 4];
         m_ifpc  = m_pc;
         m_valid = 1;
         if (m_pc + 7 >= 64'(MEM)) m_done = 1;
         else m_pc = m_pc + 4;
      end else if (rdy && m_valid) begin
         m_valid = 0;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".addr"},  bus.imem_addr, m_pc);
      check({tag, ".valid"}, 64'(bus.if_valid), 64'(m_valid));
      check({tag, ".instr"}, 64'(bus.if_instr), 64'(m_instr));
      check({tag, ".ifpc"},  bus.if_pc, m_ifpc);
      check({tag, ".done"},  64'(done), 64'(m_done));
      check({tag, ".fault"}, 64'(fault), 64'(m_fault));
      check({tag, ".faddr"}, fault_addr, m_faddr);
      check({tag, ".count"}, 64'(issue_count), 64'(m_count));
   endtask

   // Called at a negedge: drive inputs, cross one posedge, compare at next negedge
   task automatic step(input string tag, input bit rdy, input bit frz, input bit rv, input logic [63:0] tgt);
      bus.id_ready        = rdy;
      bus.freeze          = frz;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      @(posedge clk);
      model_edge(rdy, frz, rv, tgt);
      @(negedge clk);
      compare_all(tag);
   endtask

   // Called at a negedge: reset must act before any clock edge
   task automatic apply_reset();
      reset = 1'b1;
      bus.id_ready = 1'b0; bus.freeze = 1'b0;
      bus.redirect_valid = 1'b0; bus.redirect_target = 64'd0;
      #1;
      model_reset();
      check("rst.addr",  bus.imem_addr, 64'd0);
      check("rst.valid", 64'(bus.if_valid), 64'd0);
      check("rst.count", 64'(issue_count), 64'd0);
      check("rst.done",  64'(done | fault), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      compare_all("rst");
   endtask

   function automatic logic [63:0] rand_target();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 6)      return 64'($urandom_range(0, 7) * 4);
      else if (r == 7) return 64'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else if (r == 8) return 64'($urandom_range(8, 16) * 4);
      else             return {$urandom, $urandom};
   endfunction

   initial begin
      reset = 1'b1;
      bus.id_ready = 1'b0; bus.freeze = 1'b0;
      bus.redirect_valid = 1'b0; bus.redirect_target = 64'd0;
      for (int i = 0; i < 8; i++) rom[i] = 32'hE000_0000 | 32'(i * 16 + 3);
      model_reset();
      @(negedge clk);

      // Straight-line program with decode always ready
      apply_reset();
      for (int k = 1; k <= 8; k++) begin
         step("seq", 1, 0, 0, 64'd0);
         check("seq.ifpc_const", bus.if_pc, 64'(4 * (k - 1)));
      end
      check("seq.done_const", 64'(done), 64'd1);
      step("seq", 1, 0, 0, 64'd0);
      check("seq.count_const", 64'(issue_count), 64'd8);

      // Decode back-pressure: buffer holds, pc waits
      apply_reset();
      step("bp", 1, 0, 0, 64'd0);
      for (int k = 0; k < 3; k++) begin
         step("bp", 0, 0, 0, 64'd0);
         check("bp.hold_pc", bus.if_pc, 64'd0);
         check("bp.hold_instr", 64'(bus.if_instr), 64'(rom[0]));
         check("bp.hold_addr", bus.imem_addr, 64'd4);
      end
      step("bp", 1, 0, 0, 64'd0);
      check("bp.resume", bus.if_pc, 64'd4);

      // Redirect squashes the in-flight instruction
      apply_reset();
      repeat (3) step("sq", 1, 0, 0, 64'd0);
      step("sq", 1, 0, 1, 64'd16);
      check("sq.count_const", 64'(issue_count), 64'd2);
      step("sq", 1, 0, 0, 64'd0);
      check("sq.target", bus.if_pc, 64'd16);

      // Illegal targets: misaligned and past the ROM
      apply_reset();
      step("f18", 1, 0, 0, 64'd0);
      step("f18", 1, 0, 1, 64'd18);
      check("f18.fault_const", 64'(fault), 64'd1);
      check("f18.faddr_const", fault_addr, 64'd18);
      step("f18", 1, 0, 1, 64'd4);
      step("f18", 1, 0, 0, 64'd0);
      apply_reset();
      step("f32", 1, 0, 0, 64'd0);
      step("f32", 1, 0, 1, 64'd32);
      check("f32.faddr_const", fault_addr, 64'd32);
      step("f32", 1, 0, 0, 64'd0);

      // Branch out of DONE
      apply_reset();
      repeat (8) step("dn", 1, 0, 0, 64'd0);
      step("dn", 1, 0, 1, 64'd4);
      step("dn", 1, 0, 0, 64'd0);
      check("dn.resume_const", bus.if_pc, 64'd4);

      // Freeze stalls the pc, redirect still wins
      apply_reset();
      repeat (2) step("fz", 1, 0, 0, 64'd0);
      repeat (2) step("fz", 1, 1, 0, 64'd0);
      check("fz.hold_const", bus.imem_addr, 64'd8);
      step("fz", 1, 1, 1, 64'd20);
      check("fz.redir_const", bus.imem_addr, 64'd20);

      // Asynchronous reset mid-run with a valid buffer at pc=12
      apply_reset();
      repeat (3) step("ar", 0, 0, 0, 64'd0);
      step("ar", 1, 0, 0, 64'd0);
      step("ar", 1, 0, 0, 64'd0);
      apply_reset();

      // Randomized episodes
      for (int ep = 0; ep < 25; ep++) begin
         for (int i = 0; i < 8; i++) rom[i] = $urandom;
         apply_reset();
         for (int c = 0; c < 60; c++) begin
            step("rnd",
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 rand_target());
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer and fetch controller for the single-cycle/pipelined ARM CPU.
- Drives the combinational instruction ROM address and registers the returned word plus its PC into a one-entry fetch buffer, using a valid/ready handshake to decode.
- Accepts branch redirects from the datapath.
- Detects end of program and illegal redirect targets. Halts cleanly at end of program; raises a sticky fault on an illegal target.

Parameters:
- MEM_BYTES, 32, instruction ROM size in bytes; power of two, >4; must match ROM build.
- RESET_PC, 0, byte address of first fetch after reset; word-aligned, < MEM_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  64  byte address to instruction ROM; equals pc register.
- imem_instr  in  32  ROM read data, combinational from imem_addr.
- if_valid  out  1  fetch buffer holds an instruction for decode.
- if_instr  out  32  buffered instruction.
- if_pc  out  64  byte address of if_instr.
- id_ready  in  1  decode accepts if_instr this cycle.
- redirect_valid  in  1  branch taken; load redirect_target.
- redirect_target  in  64  byte address of next instruction.
- freeze  in  1  level-sensitive global stall (debug/hazard); no new fetch while high.
- done  out  1  sequential fetch ran past the last ROM word.
- fault  out  1  illegal redirect target; sticky until reset.
- fault_addr  out  64  offending redirect_target.
- issue_count  out  32  instructions accepted by decode, excluding squashed ones.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0.
  - State RUN; done=0; fault=0; fault_addr=0; issue_count=0.
- States: RUN, DONE, FAULT. done=(state==DONE). fault=(state==FAULT).
- imem_addr=pc in all states, driven combinationally.
- slot_free = !if_valid || id_ready.
- fetch = (state==RUN) && slot_free && !freeze && !redirect_valid.
- Priority per cycle: redirect > freeze > sequential fetch.
- Redirect, in RUN or DONE:
  - if_valid<=0, squashing the wrong-path instruction even if id_ready=1.
  - If redirect_target[1:0]!=0 or redirect_target+3>=MEM_BYTES: state<=FAULT, fault_addr<=redirect_target, pc unchanged.
  - Otherwise: pc<=redirect_target, state<=RUN.
  - Redirect is honored during freeze.
- Fetch:
  - if_instr<=imem_instr, if_pc<=pc, if_valid<=1.
  - If pc+4+3>=MEM_BYTES: state<=DONE, pc unchanged. Otherwise: pc<=pc+4.
- No fetch but id_ready && if_valid: if_valid<=0.
- if_valid && !id_ready: if_instr and if_pc hold stable (no drop, no duplicate).
- issue_count increments when if_valid && id_ready && !redirect_valid; wraps at 2^32.
- FAULT: absorbing; ignores redirect and id_ready; if_valid forced 0; only reset exits.
- DONE: no fetch. The final buffered instruction may still be accepted. A redirect returns to RUN, so branches resolved after the last instruction still work.
- Throughput: one instruction per cycle with id_ready=1. Latency: ROM word at pc appears on if_instr one cycle after the fetch edge.
- Reset asserted mid-operation: all state cleared within the same cycle; the next fetch is at RESET_PC.

Test Plan:
- Reset, id_ready=1, MEM_BYTES=32, ROM words W0..W7 → if_pc 0,4,...,28 on consecutive cycles; done=1 after the fetch of 28; issue_count=8.
- Hold id_ready=0 for 3 cycles after the first fetch → if_instr=W0, if_pc=0 stable; pc stays 4; after release, sequence resumes W1 with no gap or duplicate.
- redirect_valid with target 16 while if_pc=8 is valid and id_ready=1 → 8 squashed (not counted); next if_pc=16.
- Redirect target 18 → fault=1, fault_addr=18, if_valid=0 thereafter. Repeat with target 32 → same fault behaviour.
- In DONE, redirect to 4 → state RUN, fetches resume at 4. Separately: freeze high 2 cycles mid-run → no pc advance; a redirect during freeze still loads pc.
- Assert reset while if_valid=1 and pc=12 → if_valid=0 and pc=0 immediately, before the next clk edge; issue_count=0.
